// File: rtl/mem_access_ctrl.sv
// Initiator side of the unified memory bus: sequences CPU loads/stores onto instruction RAM
// (16-bit words) or data RAM (bytes), splitting 16-bit data-region accesses into two byte beats.
module mem_access_ctrl #(
    parameter int IRAM_AW  = 10,
    parameter int READ_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_write,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACC_LO, ACC_HI, RESP} state_t;

    state_t      state, next_state;
    logic [15:0] addr_q, wdata_q, result_q;
    logic        write_q, region_q, err_q;
    logic [1:0]  lat_cnt;
    logic        phase_done, wrap;

    // A store beat lasts one cycle; a load beat waits for the read data to arrive.
    assign phase_done = write_q || (lat_cnt == 2'(READ_LAT));
    assign wrap       = (addr_q == 16'hFFFF);

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign rsp_rdata = result_q;
    assign rsp_err   = err_q;

    // NOTE: every signal gets a default first so no path through the case leaves it unassigned (no latch).
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (req_valid) next_state = ACC_LO;
            ACC_LO:  if (phase_done) next_state = (region_q && !wrap) ? ACC_HI : RESP;
            ACC_HI:  if (phase_done) next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            write_q   <= 1'b0;
            region_q  <= 1'b0;
            result_q  <= '0;
            err_q     <= 1'b0;
            lat_cnt   <= '0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state     <= next_state;
            mem_write <= 1'b0;

            if (state == IDLE || state != next_state)
                lat_cnt <= '0;
            else
                lat_cnt <= lat_cnt + 2'd1;

            unique case (state)
                IDLE: if (req_valid) begin
                    addr_q    <= req_addr;
                    wdata_q   <= req_wdata;
                    write_q   <= req_write;
                    region_q  <= |req_addr[15:IRAM_AW];
                    result_q  <= '0;
                    err_q     <= 1'b0;
                    mem_addr  <= req_addr;
                    mem_wdata <= (|req_addr[15:IRAM_AW]) ? {8'h00, req_wdata[7:0]} : req_wdata;
                    mem_write <= req_write;
                end
                ACC_LO: if (phase_done) begin
                    if (!write_q)
                        result_q <= region_q ? {8'h00, mem_rdata[7:0]} : mem_rdata;
                    if (next_state == ACC_HI) begin
                        mem_addr  <= addr_q + 16'd1;
                        mem_wdata <= {8'h00, wdata_q[15:8]};
                        mem_write <= write_q;
                    end else if (region_q) begin
                        // Data region at 16'hFFFF: the high byte would wrap to 0, so it is dropped.
                        err_q <= 1'b1;
                    end
                end
                ACC_HI: if (phase_done && !write_q)
                    result_q[15:8] <= mem_rdata[7:0];
                default: ;
            endcase
        end
    end

endmodule
